// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: accepts an operand set, adds one bit pair per clock
// LSB first, then holds the WIDTH-bit sum and carry-out until the consumer takes it.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int                IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [IDX_W-1:0] bit_idx;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] acc_next;

  // One full-adder cell; the operand registers shift right so bit 0 is always current.
  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign acc_next   = {sum_bit, acc[WIDTH-1:1]};

  // Handshake and status flags come straight from the state register, no logic on inputs.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values;
  // blocking here would let a_sh shift before carry_next is evaluated from it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the shift registers are reset too, not only the control state, so that a
      // reset mid-operation leaves no stale operand bits visible to anything downstream.
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      bit_idx <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry   <= cin;
            acc     <= '0;
            bit_idx <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          acc     <= acc_next;
          carry   <= carry_next;
          bit_idx <= bit_idx + IDX_W'(1);
          // result/cout only change here, so they keep the previous sum throughout RUN.
          if (bit_idx == LAST_IDX) begin
            result <= acc_next;
            cout   <= carry_next;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_ready_and_valid: assert property (@(posedge clk) disable iff (!rstn)
    !(in_ready && out_valid));

  a_done_follows_last_bit: assert property (@(posedge clk) disable iff (!rstn)
    (state == RUN && bit_idx == LAST_IDX) |=> (state == DONE));

  a_result_stable_in_done: assert property (@(posedge clk) disable iff (!rstn)
    (state == DONE) |=> $stable(result) && $stable(cout));

endmodule
